hdk_requester: RTL
==================

HDK_REQUESTER -- requirements
Module: hdk_requester

Interface
REQ-001 Parameter TIMEOUT, default 4: number of WAIT cycles allowed for ack per request, range 1..15.
REQ-002 Parameter MAX_RETRY, default 2: number of request reissues after a timeout before the burst aborts, range 0..7.
REQ-003 clk  input  1  the single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle burst launch request, sampled only in IDLE.
REQ-006 xfer_cnt  input  8  number of req/ack beats in the burst, latched with start.
REQ-007 ack  input  1  acknowledge from the downstream handshake stage.
REQ-008 intrpt_clr  input  1  clears intrpt.
REQ-009 req  output  1  registered request to the downstream stage.
REQ-010 busy  output  1  high from the cycle after start is accepted until the burst ends.
REQ-011 done  output  1  one-cycle pulse on successful burst completion.
REQ-012 intrpt  output  1  sticky interrupt raised on abort.
REQ-013 hdk_err  output  1  sticky handshake error, cleared only by reset.
REQ-014 xfer_left  output  8  beats remaining in the current burst.
REQ-015 spur_cnt  output  4  saturating count of acks received while no request is outstanding.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE, ERR; all outputs registered.
REQ-017 IDLE: start=1 and xfer_cnt!=0 -> REQ; xfer_left<=xfer_cnt; retry counter<=0.
REQ-018 IDLE: start=1 and xfer_cnt=0 -> DONE; req never asserted.
REQ-019 REQ: req=1 for exactly one cycle, then WAIT with the wait counter at 0.
REQ-020 WAIT: req=0; ack sampled in the first WAIT cycle (one cycle after req) is on-time; ack in any WAIT cycle up to TIMEOUT is accepted.
REQ-021 On accepted ack, xfer_left decrements by 1 and the retry counter clears; if the new xfer_left=0 -> DONE, else -> REQ.
REQ-022 Consecutive beats: req is low for at least one cycle between pulses.
REQ-023 WAIT with no ack after TIMEOUT cycles: if retries<MAX_RETRY, retries+1 and -> REQ (same beat, xfer_left unchanged); else -> ERR.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 ERR: intrpt<=1 and hdk_err<=1, done stays 0, xfer_left holds the failing value; IDLE next cycle.
REQ-026 busy=1 in REQ and WAIT, and 0 in IDLE, DONE and ERR.
REQ-027 start while busy: ignored; no effect on state, counters or xfer_left.
REQ-028 ack in IDLE, REQ, DONE or ERR: ignored for the FSM; spur_cnt increments and saturates at 15.
REQ-029 intrpt_clr=1 clears intrpt next cycle; if a new ERR entry occurs in the same cycle, set wins.
REQ-030 req=1 in two consecutive cycles is forbidden under all conditions.

Reset
REQ-031 reset_n=0 at a clk edge: state<=IDLE and all counters cleared.
REQ-032 Reset output values: req=0, busy=0, done=0, intrpt=0, hdk_err=0, xfer_left=0, spur_cnt=0.
REQ-033 Reset mid-burst aborts the burst with no done and no intrpt; req is low from the reset edge onward.
REQ-034 Outputs remain at reset values while reset_n=0, regardless of start, ack and intrpt_clr.

Verification
REQ-035 start with xfer_cnt=3, ack one cycle after every req -> three req pulses spaced 2 cycles apart; xfer_left goes 3,2,1,0; done pulses once; intrpt=0.
REQ-036 start with xfer_cnt=1, TIMEOUT=4, MAX_RETRY=2, ack never asserted -> req pulses 3 times; ERR is entered; intrpt=1; hdk_err=1; xfer_left=1; done=0.
REQ-037 xfer_cnt=2, first beat acked on the 3rd WAIT cycle, second beat on time -> both beats accepted, no retry, done pulses once.
REQ-038 ack held high for 20 cycles while IDLE -> spur_cnt=15 (saturated); req stays 0.
REQ-039 start with xfer_cnt=0 -> done pulses the next cycle, with no req and busy=0 throughout.
REQ-040 Cases for reset and interrupt clear:
- reset_n=0 while in WAIT -> req, busy and xfer_left are 0 the next cycle, and no done.
- intrpt_clr asserted in the same cycle as ERR entry -> intrpt=1.

Source files
------------

// File: rtl/hdk_requester.sv
// hdk_requester: issues a burst of req/ack beats to a downstream handshake
// stage. Each beat may be reissued after a timeout, up to a retry limit,
// before the burst aborts with a sticky interrupt and error flag.
module hdk_requester #(
    parameter int TIMEOUT   = 4,  // WAIT cycles allowed for ack per request (1..15)
    parameter int MAX_RETRY = 2   // reissues after timeout before abort (0..7)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] xfer_cnt,
    input  logic       ack,
    input  logic       intrpt_clr,
    output logic       req,
    output logic       busy,
    output logic       done,
    output logic       intrpt,
    output logic       hdk_err,
    output logic [7:0] xfer_left,
    output logic [3:0] spur_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic [2:0] retry_cnt;
    logic [2:0] retry_cnt_nxt;
    logic [7:0] xfer_left_nxt;
    logic       err_set;

    // Next-state and next-counter decode for the burst sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        next_state    = state;
        wait_cnt_nxt  = wait_cnt;
        retry_cnt_nxt = retry_cnt;
        xfer_left_nxt = xfer_left;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (xfer_cnt != 8'd0) begin
                        next_state    = S_REQ;
                        xfer_left_nxt = xfer_cnt;
                        retry_cnt_nxt = 3'd0;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_REQ: begin
                next_state   = S_WAIT;
                wait_cnt_nxt = 4'd0;
            end
            S_WAIT: begin
                if (ack) begin
                    xfer_left_nxt = xfer_left - 8'd1;
                    retry_cnt_nxt = 3'd0;
                    next_state    = (xfer_left == 8'd1) ? S_DONE : S_REQ;
                end else if (wait_cnt == WAIT_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        // Reissue the same beat; xfer_left is untouched.
                        retry_cnt_nxt = retry_cnt + 3'd1;
                        next_state    = S_REQ;
                    end else begin
                        next_state = S_ERR;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Entering or sitting in ERR sets the sticky flags; this outranks a clear.
    assign err_set = (next_state == S_ERR) || (state == S_ERR);

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            retry_cnt <= 3'd0;
            xfer_left <= 8'd0;
            req       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= wait_cnt_nxt;
            retry_cnt <= retry_cnt_nxt;
            xfer_left <= xfer_left_nxt;
            req       <= (next_state == S_REQ);
            busy      <= (next_state == S_REQ) || (next_state == S_WAIT);
            done      <= (next_state == S_DONE);
        end
    end

    // Sticky interrupt (software-clearable) and handshake error (reset-only).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            intrpt  <= 1'b0;
            hdk_err <= 1'b0;
        end else begin
            if (err_set) begin
                intrpt  <= 1'b1;
                hdk_err <= 1'b1;
            end else if (intrpt_clr) begin
                intrpt <= 1'b0;
            end
        end
    end

    // Saturating count of acks that arrive while no request is outstanding.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spur_cnt <= 4'd0;
        end else if (ack && (state != S_WAIT) && (spur_cnt != 4'hF)) begin
            spur_cnt <= spur_cnt + 4'd1;
        end
    end

endmodule
